// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with a bounded hold time and a
// one-cycle bus-turnaround gap between owners. Every output is a flop.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] select,
  output logic       valid
);

  localparam logic [4:0] HOLD_LIMIT = 5'(MAX_HOLD);
  localparam logic [4:0] CNT_MAX    = 5'd31;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] select_q, select_d;
  logic       valid_q, valid_d;
  logic       release_now;

  // First set request bit at or after p, wrapping modulo 8. Scanning from the
  // far end down lets the nearest hit overwrite the others.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] w;
    logic [2:0] idx;
    w = p;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  // done, a dropped request and the hold limit all collapse into one release.
  assign release_now = done || !req[select_q] || (cnt_q == HOLD_LIMIT);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    select_d = select_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (req != 8'h00) begin
          state_d  = OWNED;
          select_d = pick(req, ptr_q);
          grant_d  = 8'b1 << pick(req, ptr_q);
          valid_d  = 1'b1;
          cnt_d    = 5'd1;
        end
      end
      OWNED: begin
        if (release_now) begin
          state_d = IDLE;
          grant_d = 8'h00;
          valid_d = 1'b0;
          ptr_d   = select_q + 3'd1;
          cnt_d   = 5'd0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 3'd0;
      cnt_q    <= 5'd0;
      grant_q  <= 8'h00;
      select_q <= 3'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      valid_q  <= valid_d;
    end
  end

  assign grant  = grant_q;
  assign select = select_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: three hold limits run side by side
// against an owner/queue-level reference model, plus directed corner cases.
module tb_rr_arbiter_8;

  logic       clock;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] g [3];
  logic [2:0] s [3];
  logic       v [3];

  int total = 0;
  int bad   = 0;

  rr_arbiter_8 #(.MAX_HOLD(16)) u_dut16 (
    .clock(clock), .reset(reset), .req(req), .done(done),
    .grant(g[0]), .select(s[0]), .valid(v[0])
  );
  rr_arbiter_8 #(.MAX_HOLD(4)) u_dut4 (
    .clock(clock), .reset(reset), .req(req), .done(done),
    .grant(g[1]), .select(s[1]), .valid(v[1])
  );
  rr_arbiter_8 #(.MAX_HOLD(1)) u_dut1 (
    .clock(clock), .reset(reset), .req(req), .done(done),
    .grant(g[2]), .select(s[2]), .valid(v[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: who owns the bus, for how long, and where the next
  // search starts. owner < 0 means nobody.
  typedef struct {
    int owner;
    int held;
    int ptr;
    int last_sel;
  } mdl_t;

  mdl_t m [3];
  int   hold_lim [3] = '{16, 4, 1};

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.owner    = -1;
    n.held     = 0;
    n.ptr      = 0;
    n.last_sel = 0;
    return n;
  endfunction

  function automatic mdl_t mdl_next(mdl_t cur, logic [7:0] r, logic d, int lim);
    mdl_t n;
    bit   found;
    n = cur;
    found = 0;
    if (cur.owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(cur.ptr + k) % 8]) begin
          found      = 1;
          n.owner    = (cur.ptr + k) % 8;
          n.held     = 1;
          n.last_sel = n.owner;
        end
      end
    end else if (d || !r[cur.owner] || cur.held == lim) begin
      n.ptr   = (cur.owner + 1) % 8;
      n.owner = -1;
      n.held  = 0;
    end else begin
      n.held = (cur.held < 31) ? cur.held + 1 : 31;
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_grant(mdl_t x);
    logic [7:0] one;
    one = 8'h01;
    return (x.owner < 0) ? 8'h00 : (one << x.owner);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mdl_grant[%0d]", i), 32'(g[i]), 32'(exp_grant(m[i])));
      check($sformatf("mdl_select[%0d]", i), 32'(s[i]), 32'(m[i].last_sel));
      check($sformatf("mdl_valid[%0d]", i), 32'(v[i]), 32'(m[i].owner >= 0));
    end
  endtask

  // One clock: model advances on the edge with the inputs the DUT saw, then
  // outputs are compared 1ns later.
  task automatic tick();
    @(posedge clock);
    if (!reset)
      for (int i = 0; i < 3; i++) m[i] = mdl_next(m[i], req, done, hold_lim[i]);
    #1;
    check_models();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    for (int i = 0; i < 3; i++) m[i] = mdl_reset();
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_grant[%0d]", i), 32'(g[i]), 32'h00);
      check($sformatf("rst_select[%0d]", i), 32'(s[i]), 32'h0);
      check($sformatf("rst_valid[%0d]", i), 32'(v[i]), 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Idle with no requests, then req=8'h24 with done one cycle into each
    // grant, then done while idle which must leave ptr alone.
    for (int i = 0; i < 5; i++) tbl[i] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[5]  = '{8'h24, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[6]  = '{8'h24, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[7]  = '{8'h24, 1'b1, 8'h00, 3'd2, 1'b0};
    tbl[8]  = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1};
    tbl[9]  = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1};
    tbl[10] = '{8'h24, 1'b1, 8'h00, 3'd5, 1'b0};
    tbl[11] = '{8'h24, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[12] = '{8'h24, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[13] = '{8'h24, 1'b1, 8'h00, 3'd2, 1'b0};
    tbl[14] = '{8'h00, 1'b1, 8'h00, 3'd2, 1'b0};
    tbl[15] = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1};

    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;

    do_reset();
    for (int i = 0; i < 16; i++) begin
      req  = tbl[i].req;
      done = tbl[i].done;
      tick();
      check($sformatf("tbl_grant[%0d]", i), 32'(g[0]), 32'(tbl[i].grant));
      check($sformatf("tbl_select[%0d]", i), 32'(s[0]), 32'(tbl[i].sel));
      check($sformatf("tbl_valid[%0d]", i), 32'(v[0]), 32'(tbl[i].valid));
    end

    // Two requesters held, no done: hold limit 4 gives 4-on/1-off alternating
    // 0 and 7; hold limit 1 gives 1-on/1-off alternating.
    do_reset();
    req  = 8'h81;
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      int          own4, own1;
      logic [7:0]  one;
      one  = 8'h01;
      own4 = ((k / 5) % 2 != 0) ? 7 : 0;
      own1 = ((k / 2) % 2 != 0) ? 7 : 0;
      tick();
      check($sformatf("h4_valid[%0d]", k), 32'(v[1]), 32'((k % 5) < 4));
      check($sformatf("h4_select[%0d]", k), 32'(s[1]), 32'(own4));
      check($sformatf("h4_grant[%0d]", k), 32'(g[1]), ((k % 5) < 4) ? 32'(one << own4) : 32'h0);
      check($sformatf("h1_valid[%0d]", k), 32'(v[2]), 32'((k % 2) == 0));
      check($sformatf("h1_select[%0d]", k), 32'(s[2]), 32'(own1));
    end

    // Owner 3 loses its request and signals done in the same cycle.
    do_reset();
    req = 8'h08;
    tick();
    check("own3_grant", 32'(g[0]), 32'h08);
    req  = 8'h40;
    done = 1'b1;
    tick();
    check("own3_release", 32'(g[0]), 32'h00);
    check("own3_release_valid", 32'(v[0]), 32'h0);
    done = 1'b0;
    tick();
    check("own3_next_grant", 32'(g[0]), 32'h40);
    check("own3_next_select", 32'(s[0]), 32'h6);

    // Reset asserted between edges while owner 1 holds with a count of 2.
    do_reset();
    req = 8'h02;
    tick();
    tick();
    check("own1_held", 32'(g[0]), 32'h02);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) m[i] = mdl_reset();
    #1;
    check("async_rst_grant", 32'(g[0]), 32'h00);
    check("async_rst_valid", 32'(v[0]), 32'h0);
    req = 8'hFF;
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("post_rst_select", 32'(s[0]), 32'h0);
    check("post_rst_grant", 32'(g[0]), 32'h01);

    // Randomised traffic; requests change occasionally so holds can run long.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(3) == 0) req = 8'($urandom);
      if ($urandom_range(15) == 0) req = 8'h00;
      done = ($urandom_range(4) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 16, SHALL set the maximum consecutive cycles one owner holds the grant (legal range 1..31).
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous, active-high; while high all state is held at reset values.
REQ-004 req  input  8  SHALL carry one request bit per requester; bit i maps to mux data input in_i.
REQ-005 done  input  1  SHALL be the current owner's end-of-transfer strobe; it is ignored when valid=0.
REQ-006 grant  output  8  SHALL be the one-hot grant vector, all zeros when no owner.
REQ-007 select  output  3  SHALL be the binary index of the owner, driving the 8:1 one-bit mux select directly.
REQ-008 valid  output  1  SHALL be high exactly when grant is non-zero.
REQ-009 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-010 The FSM SHALL have two states: IDLE and OWNED.
REQ-011 IDLE with req==0: SHALL stay in IDLE with grant=0, valid=0, and select holding its last value.
REQ-012 IDLE with req!=0 at edge N: SHALL pick winner w, the first set req bit scanning ptr, ptr+1, ... mod 8.
REQ-013 After that pick, the FSM SHALL enter OWNED, with grant=1<<w, select=w, valid=1 visible after edge N (one-cycle latency).
REQ-014 On entry to OWNED, hold counter cnt SHALL load 1.
REQ-015 In OWNED, cnt SHALL increment each cycle the grant is kept, saturating at 31.
REQ-016 OWNED SHALL release at the edge where any of these holds: done=1, req[select]=0, or cnt==MAX_HOLD.
REQ-017 On release: state SHALL go to IDLE, grant=0, valid=0, ptr=(select+1) mod 8, cnt=0.
REQ-018 After any release, grant SHALL be low for exactly one cycle (bus turnaround) before the next owner is granted, even when other requests are pending.
REQ-019 Requests other than the owner's SHALL have no effect while in OWNED.
REQ-020 Simultaneous done and req[select] drop SHALL be treated as a single release, with ptr advanced once.
REQ-021 With MAX_HOLD=1, each owner SHALL hold the grant exactly one cycle.
REQ-022 ptr wrap: owner 7 released SHALL give ptr=0.
REQ-023 A requester that keeps req high SHALL be re-granted no sooner than after every other pending requester has been served once (round-robin fairness).
REQ-024 grant and select SHALL always be consistent, with grant==(1<<select) whenever valid=1.

Reset
REQ-025 Reset SHALL force state=IDLE, ptr=0, cnt=0, grant=8'h00, select=3'd0, valid=0.
REQ-026 Assertion of reset mid-ownership SHALL drop grant and valid asynchronously, without waiting for a clock edge.
REQ-027 After reset deassertion, the first arbitration SHALL use ptr=0.

Verification
REQ-028 Reset then req=8'h00 for 5 cycles -> grant=8'h00, valid=0, select=0 throughout.
REQ-029 Reset, req=8'h24 held, done pulsed one cycle after each grant:
- Grant order SHALL be 8'h04 (select=2), gap, 8'h20 (select=5), gap, 8'h04.
- Each grant SHALL last 2 cycles, with a 1-cycle gap between grants.
REQ-030 MAX_HOLD=4, req=8'h81 held, done=0:
- Grants SHALL alternate select=0 and select=7, each valid for exactly 4 cycles, with a 1-cycle gap.
- ptr SHALL wrap 7->0.
REQ-031 Owner 3 granted, then req[3] and done drop in the same cycle with req[6] set -> single release, then after the gap grant=8'h40.
REQ-032 Owner 1 granted with cnt=2, reset pulsed between clock edges -> grant=8'h00 and valid=0 immediately.
- After release of reset with req=8'hFF, the first grant SHALL be select=0.
REQ-033 done pulsed while valid=0 with req=8'h00 -> no state change; ptr unchanged, verified by the next grant order.
